// File: rtl/ctrl_cell_pkg.sv
// ctrl_cell_pkg: definitions shared by the cell-chain elements.
//   DATA_MSB   - default index of the top data bit
//   data_t     - signed data word at the default width
//   ma_state_t - moving-average window state (FILL / RUN)
//   acc_width  - accumulator width for a 2^log2_depth window of w-bit samples
package ctrl_cell_pkg;

  localparam int DATA_MSB = 31;

  typedef logic signed [DATA_MSB:0] data_t;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } ma_state_t;

  // A sum of 2^log2_depth signed w-bit words needs log2_depth extra bits
  // so it can never overflow.
  function automatic int acc_width(input int w, input int log2_depth);
    return w + log2_depth;
  endfunction

endpackage

// File: rtl/moving_average_sample_ring.sv
// sample_ring: DEPTH x W register ring buffer with a write pointer.
// The read port always shows the entry the next write will overwrite,
// which is the oldest sample in the window.
// Ports:
//   clk     - clock, rising edge
//   rst     - synchronous active-high reset, zeroes entries and pointer
//   clear   - synchronous flush; if wr_en is also high, wr_data lands in
//             entry 0 and the pointer moves to 1
//   wr_en   - write wr_data at the pointer and advance it
//   wr_data - sample to store
//   oldest  - entry at the write pointer
module sample_ring
  import ctrl_cell_pkg::*;
#(
  parameter int W          = DATA_MSB + 1,
  parameter int LOG2_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] oldest
);

  localparam int DEPTH = 1 << LOG2_DEPTH;

  logic [W-1:0]          ring [DEPTH];
  logic [LOG2_DEPTH-1:0] wr_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ring[i] <= '0;
      wr_ptr <= '0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) ring[i] <= '0;
      if (wr_en) ring[0] <= wr_data;
      wr_ptr <= LOG2_DEPTH'(wr_en);
    end else if (wr_en) begin
      ring[wr_ptr] <= wr_data;
      wr_ptr       <= wr_ptr + LOG2_DEPTH'(1);
    end
  end

  assign oldest = ring[wr_ptr];

endmodule

// File: rtl/moving_average.sv
// moving_average: boxcar average over the last 2^LOG2_DEPTH valid samples.
// Build option: define MOVING_AVERAGE_ROUND_EN for round-half-up output;
// otherwise the average is floored by arithmetic shift.
// Ports:
//   clk         - clock, rising edge
//   rst         - synchronous active-high reset (priority over all else)
//   data_in     - signed sample
//   data_en     - sample valid strobe, may stay high every cycle
//   clear       - flush the window without touching data_out
//   data_out    - signed average, held between updates
//   data_en_out - one-cycle pulse when data_out has just been updated
//   state       - current window state, for observation
// Handshake: there is no back-pressure. A sample is consumed on every rising
// edge where data_en=1; data_en_out is high for exactly the cycle after an
// edge that updated data_out, with data_out valid in that cycle and held after.
module moving_average
  import ctrl_cell_pkg::*;
#(
  parameter int MSB        = DATA_MSB,
  parameter int LOG2_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [MSB:0] data_in,
  input  logic               data_en,
  input  logic               clear,
  output logic signed [MSB:0] data_out,
  output logic               data_en_out,
  output ma_state_t          state
);

  localparam int W     = MSB + 1;
  localparam int AW    = acc_width(W, LOG2_DEPTH);
  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int FW    = LOG2_DEPTH + 1;

  logic signed [AW-1:0] sum_q, sum_next, sum_upd;
  logic [FW-1:0]        fill_q, fill_next;
  ma_state_t            state_next;
  logic                 pulse_next;
  logic signed [W-1:0]  oldest;
  logic signed [W-1:0]  avg;

  sample_ring #(
    .W          (W),
    .LOG2_DEPTH (LOG2_DEPTH)
  ) u_ring (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .wr_en   (data_en),
    .wr_data (data_in),
    .oldest  (oldest)
  );

  // Running sum after replacing the oldest sample; during FILL the oldest
  // entries are still zero, so the same update works from the first sample.
  always_comb begin
    sum_upd = sum_q + AW'(data_in) - AW'(oldest);
  end

`ifdef MOVING_AVERAGE_ROUND_EN
  localparam int HALF = 1 << (LOG2_DEPTH - 1);
  logic signed [AW:0] rnd_sum;
  logic signed [AW:0] rnd_shift;
  always_comb begin
    rnd_sum   = (AW+1)'(sum_upd) + (AW+1)'(HALF);
    rnd_shift = rnd_sum >>> LOG2_DEPTH;
    avg       = rnd_shift[W-1:0];
  end
`else
  logic signed [AW-1:0] flr_shift;
  always_comb begin
    flr_shift = sum_upd >>> LOG2_DEPTH;
    avg       = flr_shift[W-1:0];
  end
`endif

  always_comb begin
    state_next = state;
    fill_next  = fill_q;
    sum_next   = sum_q;
    pulse_next = 1'b0;
    if (clear) begin
      // A sample arriving with clear becomes the first entry of the new window.
      state_next = FILL;
      sum_next   = data_en ? AW'(data_in) : '0;
      fill_next  = FW'(data_en);
    end else if (data_en) begin
      sum_next = sum_upd;
      if (fill_q != FW'(DEPTH)) fill_next = fill_q + FW'(1);
      if (state == RUN || fill_q == FW'(DEPTH - 1)) begin
        pulse_next = 1'b1;
        state_next = RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FILL;
      sum_q       <= '0;
      fill_q      <= '0;
      data_out    <= '0;
      data_en_out <= 1'b0;
    end else begin
      state       <= state_next;
      sum_q       <= sum_next;
      fill_q      <= fill_next;
      data_en_out <= pulse_next;
      if (pulse_next) data_out <= avg;
    end
  end

endmodule
